// File: rtl/cursor_navigator.sv
// Cursor navigator for a 9x9 board. Button presses (with auto-repeat)
// move the cursor in the requested direction to the next cell whose
// visibility code is not 2'b11. The search takes one candidate per cycle.
module cursor_navigator #(
    parameter logic [2:0]  CARREGANDO    = 3'b010,
    parameter logic [2:0]  NAVEGAR       = 3'b011,
    parameter logic [23:0] REPEAT_DELAY  = 24'd12_500_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   current_state,
    input  logic         up_button,
    input  logic         down_button,
    input  logic         left_button,
    input  logic         right_button,
    input  logic [323:0] board,
    input  logic [161:0] visibilities,
    output logic [3:0]   row,
    output logic [3:0]   col,
    output logic [7:0]   index,
    output logic [3:0]   cell_value,
    output logic         busy,
    output logic         no_target
);

    typedef enum logic {IDLE, SEARCH} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t      state, next_state;
    dir_t        req_dir, dir;
    logic [3:0]  btn, btn_prev, press, req;
    logic        in_nav, in_load, held_one, same_held, fire;
    logic [23:0] rpt_cnt;
    logic [3:0]  cand_row, cand_col;
    logic [6:0]  steps, step_limit;
    logic [6:0]  cur_n, cand_n;
    logic        cand_ok;
    logic        start, commit, give_up, advance;
    logic [7:0]  first_rc, next_rc;

    // One step in direction d from (r,c); horizontal moves wrap across rows
    // (reading order over 81 cells), vertical moves wrap within the column.
    function automatic logic [7:0] step_rc(input dir_t d, input logic [3:0] r,
                                           input logic [3:0] c);
        logic [3:0] nr, nc;
        nr = r;
        nc = c;
        case (d)
            DIR_UP:   nr = (r == 4'd0) ? 4'd8 : r - 4'd1;
            DIR_DOWN: nr = (r == 4'd8) ? 4'd0 : r + 4'd1;
            DIR_LEFT: begin
                if (c == 4'd0) begin
                    nc = 4'd8;
                    nr = (r == 4'd0) ? 4'd8 : r - 4'd1;
                end else begin
                    nc = c - 4'd1;
                end
            end
            default: begin
                if (c == 4'd8) begin
                    nc = 4'd0;
                    nr = (r == 4'd8) ? 4'd0 : r + 4'd1;
                end else begin
                    nc = c + 4'd1;
                end
            end
        endcase
        return {nr, nc};
    endfunction

    assign btn       = {up_button, down_button, left_button, right_button};
    assign in_nav    = (current_state == NAVEGAR);
    assign in_load   = (current_state == CARREGANDO);
    assign press     = btn & ~btn_prev;
    assign held_one  = in_nav && $onehot(btn);
    assign same_held = (btn == btn_prev);
    assign fire      = held_one && same_held && (rpt_cnt == REPEAT_DELAY - 24'd1);
    assign req       = press | (fire ? btn : 4'b0000);

    assign cur_n      = 7'(row) * 7'd9 + 7'(col);
    assign cand_n     = 7'(cand_row) * 7'd9 + 7'(cand_col);
    assign index      = {cur_n, 1'b0};
    assign cand_ok    = (visibilities[{cand_n, 1'b0} +: 2] != 2'b11);
    assign step_limit = (dir == DIR_LEFT || dir == DIR_RIGHT) ? 7'd80 : 7'd8;
    assign first_rc   = step_rc(req_dir, row, col);
    assign next_rc    = step_rc(dir, cand_row, cand_col);
    assign busy       = (state == SEARCH);

    // Pick one direction out of simultaneous requests: up > down > left > right
    always_comb begin
        req_dir = DIR_RIGHT;
        if (req[3])      req_dir = DIR_UP;
        else if (req[2]) req_dir = DIR_DOWN;
        else if (req[1]) req_dir = DIR_LEFT;
    end

    // Previous button levels for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_prev <= 4'b0000;
        else       btn_prev <= btn;
    end

    // Auto-repeat counter: counts held cycles of a single steady direction
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           rpt_cnt <= '0;
        else if (!held_one)  rpt_cnt <= '0;
        else if (!same_held) rpt_cnt <= 24'd1;
        else if (fire)       rpt_cnt <= REPEAT_DELAY - REPEAT_PERIOD;
        else                 rpt_cnt <= rpt_cnt + 24'd1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next state and per-cycle search decisions
    always_comb begin
        next_state = state;
        start      = 1'b0;
        commit     = 1'b0;
        give_up    = 1'b0;
        advance    = 1'b0;
        if (!in_nav) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        start      = 1'b1;
                        next_state = SEARCH;
                    end
                end
                default: begin
                    if (cand_ok) begin
                        commit     = 1'b1;
                        next_state = IDLE;
                    end else if (steps == step_limit) begin
                        give_up    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        advance    = 1'b1;
                    end
                end
            endcase
        end
    end

    // Search candidate and step count; only meaningful while searching
    always_ff @(posedge clk) begin
        if (start) begin
            dir                  <= req_dir;
            {cand_row, cand_col} <= first_rc;
            steps                <= 7'd1;
        end else if (advance) begin
            {cand_row, cand_col} <= next_rc;
            steps                <= steps + 7'd1;
        end
    end

    // Cursor outputs: forced on board load, updated by search results, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row        <= 4'd0;
            col        <= 4'd0;
            cell_value <= 4'd0;
            no_target  <= 1'b0;
        end else if (in_load) begin
            row        <= 4'd0;
            col        <= 4'd0;
            cell_value <= board[3:0];
            no_target  <= 1'b0;
        end else if (in_nav) begin
            if (commit) begin
                row        <= cand_row;
                col        <= cand_col;
                cell_value <= board[{cand_n, 2'b00} +: 4];
                no_target  <= 1'b0;
            end else if (give_up) begin
                no_target  <= 1'b1;
            end else if (state == IDLE) begin
                cell_value <= board[{cur_n, 2'b00} +: 4];
            end
        end
    end

endmodule

// File: tb/tb_cursor_navigator.sv
// Testbench for cursor_navigator: a scoreboard of expected search outcomes
// filled by the stimulus, drained by a monitor on every end of a search.
module tb_cursor_navigator;

    localparam logic [2:0] CARREGANDO = 3'b010;
    localparam logic [2:0] NAVEGAR    = 3'b011;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   current_state;
    logic         up_button, down_button, left_button, right_button;
    logic [323:0] board;
    logic [161:0] vis;
    logic [3:0]   row, col, cell_value;
    logic [7:0]   index;
    logic         busy, no_target;

    typedef struct {
        int row; int col; int idx; int cv; int nt; int blen; int start;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mdl_n    = 0;
    int   mdl_nt   = 0;

    cursor_navigator #(
        .CARREGANDO   (CARREGANDO),
        .NAVEGAR      (NAVEGAR),
        .REPEAT_DELAY (24'd4),
        .REPEAT_PERIOD(24'd2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .current_state(current_state),
        .up_button    (up_button),
        .down_button  (down_button),
        .left_button  (left_button),
        .right_button (right_button),
        .board        (board),
        .visibilities (vis),
        .row          (row),
        .col          (col),
        .index        (index),
        .cell_value   (cell_value),
        .busy         (busy),
        .no_target    (no_target)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cell reached after k steps in direction d (0 up, 1 down, 2 left, 3 right)
    function automatic int cand(input int d, input int n, input int k);
        int r, c;
        r = n / 9;
        c = n % 9;
        case (d)
            0:       return ((r + 9 - k) % 9) * 9 + c;
            1:       return ((r + k) % 9) * 9 + c;
            2:       return (n + 81 - k) % 81;
            default: return (n + k) % 81;
        endcase
    endfunction

    // Compute the outcome of a move request and queue it; advance the model
    task automatic add_exp(input int d, input int start);
        exp_t e;
        int lim, hit, n;
        lim = (d >= 2) ? 80 : 8;
        hit = -1;
        for (int k = 1; k <= lim; k++)
            if (hit < 0 && vis[2*cand(d, mdl_n, k) +: 2] != 2'b11) hit = k;
        n       = (hit < 0) ? mdl_n : cand(d, mdl_n, hit);
        e.row   = n / 9;
        e.col   = n % 9;
        e.idx   = 2 * n;
        e.cv    = int'(board[4*n +: 4]);
        e.nt    = (hit < 0) ? 1 : 0;
        e.blen  = (hit < 0) ? lim : hit;
        e.start = start;
        sb.push_back(e);
        mdl_n  = n;
        mdl_nt = e.nt;
    endtask

    task automatic set_btns(input logic [3:0] m);
        {up_button, down_button, left_button, right_button} = m;
    endtask

    // One-cycle press of direction d plus any extra buttons in 'also'
    task automatic press(input int d, input logic [3:0] also);
        logic [3:0] m;
        m = 4'b1000 >> d;
        add_exp(d, cyc + 1);
        set_btns(m | also);
        @(negedge clk);
        set_btns(4'b0000);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("search_completed", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic load();
        current_state = CARREGANDO;
        @(negedge clk);
        chk("load_row", row, 0);
        chk("load_col", col, 0);
        chk("load_cell_value", cell_value, int'(board[3:0]));
        chk("load_no_target", no_target, 0);
        current_state = NAVEGAR;
        mdl_n  = 0;
        mdl_nt = 0;
        @(negedge clk);
    endtask

    task automatic vis_all(input logic [1:0] v);
        for (int i = 0; i < 81; i++) vis[2*i +: 2] = v;
    endtask

    // Monitor: every falling edge of busy is one search outcome
    initial begin
        exp_t e;
        logic busy_q;
        int   busy_len, busy_start;
        busy_q = 1'b0;
        busy_len = 0;
        busy_start = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && !busy_q) begin
                busy_start = cyc;
                busy_len   = 0;
            end
            if (busy === 1'b1) busy_len++;
            if (busy !== 1'b1 && busy_q) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_move: row %0d col %0d, expected no move", row, col);
                end else begin
                    e = sb.pop_front();
                    chk("move_row", row, e.row);
                    chk("move_col", col, e.col);
                    chk("move_index", index, e.idx);
                    chk("move_cell_value", cell_value, e.cv);
                    chk("move_no_target", no_target, e.nt);
                    if (e.blen >= 0)  chk("busy_cycles", busy_len, e.blen);
                    if (e.start >= 0) chk("search_start", busy_start, e.start);
                end
            end
            busy_q = (busy === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ab;
        int   c0;
        reset = 1'b1;
        current_state = NAVEGAR;
        set_btns(4'b0000);
        for (int i = 0; i < 81; i++) board[4*i +: 4] = 4'($urandom_range(0, 15));
        vis_all(2'b00);
        repeat (3) @(negedge clk);
        chk("reset_row", row, 0);
        chk("reset_col", col, 0);
        chk("reset_index", index, 0);
        chk("reset_cell_value", cell_value, 0);
        chk("reset_busy", busy, 0);
        chk("reset_no_target", no_target, 0);
        reset = 1'b0;
        @(negedge clk);
        load();

        // Immediate neighbour to the right
        press(3, 4'b0000);
        wait_done();
        chk("s1_index", index, 2);

        // Skip three hidden cells
        load();
        for (int i = 1; i <= 3; i++) vis[2*i +: 2] = 2'b11;
        press(3, 4'b0000);
        wait_done();
        chk("s2_col", col, 4);
        chk("s2_index", index, 8);

        // Wraparound up and left from cell 0
        load();
        vis_all(2'b00);
        press(0, 4'b0000);
        wait_done();
        chk("s3_up_row", row, 8);
        chk("s3_up_index", index, 144);
        load();
        press(2, 4'b0000);
        wait_done();
        chk("s3_left_index", index, 160);

        // Only cell 40 eligible: reach it, then searches that find nothing
        load();
        vis_all(2'b11);
        vis[80 +: 2] = 2'b00;
        press(3, 4'b0000);
        wait_done();
        chk("s4_index", index, 80);
        press(3, 4'b0000);
        wait_done();
        chk("s4_no_target", no_target, 1);
        press(0, 4'b0000);
        wait_done();
        press(2, 4'b0000);
        wait_done();
        vis[82 +: 2] = 2'b10;
        press(3, 4'b0000);
        wait_done();
        chk("s4_cleared", no_target, 0);

        // Up and right on the same edge: only up moves
        vis_all(2'b00);
        press(0, 4'b0001);
        wait_done();
        repeat (6) @(negedge clk);
        chk("s5_extra_moves", sb.size(), 0);

        // Auto-repeat: right held for 8 sampled edges
        c0 = cyc;
        add_exp(3, c0 + 1);
        add_exp(3, c0 + 4);
        add_exp(3, c0 + 6);
        add_exp(3, c0 + 8);
        set_btns(4'b0001);
        repeat (8) @(negedge clk);
        set_btns(4'b0000);
        wait_done();
        repeat (6) @(negedge clk);

        // Outside NAVEGAR the cursor holds and presses are ignored
        current_state = 3'b101;
        @(negedge clk);
        set_btns(4'b0100);
        @(negedge clk);
        set_btns(4'b0000);
        repeat (4) @(negedge clk);
        chk("hold_row", row, mdl_n / 9);
        chk("hold_col", col, mdl_n % 9);
        chk("hold_busy", busy, 0);
        current_state = NAVEGAR;
        @(negedge clk);

        // Board load during a long search aborts without committing
        load();
        vis_all(2'b11);
        vis[1:0] = 2'b00;
        ab = '{row: 0, col: 0, idx: 0, cv: int'(board[3:0]), nt: 0, blen: 5, start: cyc + 1};
        sb.push_back(ab);
        set_btns(4'b0001);
        @(negedge clk);
        set_btns(4'b0000);
        repeat (4) @(negedge clk);
        current_state = CARREGANDO;
        @(negedge clk);
        current_state = NAVEGAR;
        mdl_n = 0;
        mdl_nt = 0;
        wait_done();

        // Reset during a long search
        ab = '{row: 0, col: 0, idx: 0, cv: 0, nt: 0, blen: -1, start: cyc + 1};
        sb.push_back(ab);
        set_btns(4'b0001);
        @(negedge clk);
        set_btns(4'b0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        reset = 1'b0;
        mdl_n = 0;
        mdl_nt = 0;
        wait_done();

        // Randomized moves over random boards
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 81; i++) begin
                board[4*i +: 4] = 4'($urandom_range(0, 15));
                vis[2*i +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            end
            @(negedge clk);
            press(int'($urandom_range(0, 3)), 4'b0000);
            wait_done();
        end

        chk("final_queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cursor_navigator.md
CURSOR_NAVIGATOR -- requirements
Module: cursor_navigator

Interface
REQ-001 Parameters SHALL be: CARREGANDO, default 3'b010, game-state code for board loading; NAVEGAR, default 3'b011, game-state code for cursor movement; REPEAT_DELAY, default 24'd12_500_000, cycles held before first auto-repeat; REPEAT_PERIOD, default 24'd2_500_000, cycles between later repeats.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- current_state  in  3  game FSM state.
- up_button, down_button, left_button, right_button  in  1 each  debounced, level-high.
- board  in  324  solution map, cell n at [4n+:4].
- visibilities  in  162  cell n at [2n+:2].
- row, col  out  4 each  cursor position, 0..8.
- index  out  8  bit offset of the cursor cell in visibilities.
- cell_value  out  4  solution digit under the cursor.
- busy  out  1  search in progress.
- no_target  out  1  last search found no eligible cell.

Function
REQ-003 Cell number n SHALL be row*9+col, and index SHALL equal 2n, driven combinationally from registered row/col (max 160).
REQ-004 A cell SHALL be eligible when its visibilities pair is not 2'b11.
REQ-005 Press detection SHALL be a rising-edge detector per button, using a registered previous level.
REQ-006 Auto-repeat SHALL work as follows: while exactly one direction stays held in NAVEGAR, a 24-bit counter generates a move request after REPEAT_DELAY cycles and every REPEAT_PERIOD cycles after that; the counter clears on release, on a direction change, or outside NAVEGAR.
REQ-007 Simultaneous requests SHALL resolve by priority up > down > left > right, and only one move SHALL be taken per request.
REQ-008 The FSM SHALL have two states, IDLE and SEARCH.
REQ-009 In IDLE, in NAVEGAR, a move request SHALL latch the direction, set the candidate to the first step from the cursor, clear the step count to 1, and enter SEARCH.
REQ-010 Steps SHALL be:
- right: n+1 mod 81.
- left: n-1 mod 81, so 0 goes to 80.
- down: row+1 mod 9, col unchanged.
- up: row-1 mod 9, col unchanged.
REQ-011 In SEARCH, each cycle SHALL do one of:
- candidate eligible: commit it to row/col, load cell_value = board[4*cand+:4] on the same edge, clear no_target, return to IDLE.
- candidate not eligible: take the next step and increment the step count.
REQ-012 A search SHALL give up when the step count reaches 80 (left/right) or 8 (up/down) with no hit; the cursor then stays unchanged, no_target is set to 1, and the FSM returns to IDLE.
REQ-013 A search with an eligible immediate neighbour SHALL commit on the second rising edge after the press is first sampled high; each additional ineligible cell SHALL add one cycle.
REQ-014 busy SHALL be 1 exactly while in SEARCH, and requests arriving during SEARCH SHALL be dropped, not queued.
REQ-015 When current_state leaves NAVEGAR during SEARCH, the FSM SHALL abort to IDLE on the next edge without committing.
REQ-016 When current_state == CARREGANDO, row/col SHALL be forced to 0, cell_value to board[3:0], the FSM to IDLE, and no_target to 0.
REQ-017 In any state other than NAVEGAR or CARREGANDO, all cursor outputs SHALL hold.
REQ-018 cell_value SHALL also refresh every cycle in IDLE from board at the current cursor, so that a board load is tracked.

Reset
REQ-019 On reset: row=0, col=0, cell_value=0, busy=0, no_target=0, FSM=IDLE, repeat counter=0, previous-button registers=0.
REQ-020 Reset asserted mid-SEARCH SHALL abandon the search immediately and asynchronously.

Verification
REQ-021 Bench scenarios:
- Cursor (0,0), all cells visibility 00, one-cycle right pulse -> col=1 two edges later, index=2, busy high for 1 cycle.
- Cursor (0,0), cells 1-3 visibility 11, right press -> cursor (0,4), index=8, busy high for 4 cycles.
- Cursor (0,0), up press -> row=8, col=0, index=144; left press from cell 0 -> cell 80, index=160.
- All cells except cell 40 at 11, cursor at 40, right press -> cursor unchanged, no_target=1 after 80 SEARCH cycles.
- Up and right pressed on the same edge -> only the up move occurs; right held with REPEAT_DELAY=4, REPEAT_PERIOD=2 -> moves at hold cycles 1, 4, 6, 8.
- Reset or current_state=CARREGANDO asserted mid-SEARCH -> busy=0 and cursor (0,0) with no commit.
